// File: rtl/sd_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sd_resp_pkg
// Purpose  : Shared types, token lengths and helpers for the card-side SD
//            command responder (state encoding, response types, CRC7
//            polynomial, response-token assembly).
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package sd_resp_pkg;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_R1   = 2'd1,
    RESP_R2   = 2'd2,
    RESP_R3   = 2'd3
  } resp_type_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RX        = 3'd1,
    ST_CHECK     = 3'd2,
    ST_WAIT_RESP = 3'd3,
    ST_NCR       = 3'd4,
    ST_TX        = 3'd5
  } state_t;

  localparam int         CMD_LEN   = 48;
  localparam int         R2_LEN    = 136;
  localparam logic [6:0] CRC7_POLY = 7'h09;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Left-aligned response token. The CRC field is left as ones; for R1/R2
  // the transmitter substitutes the running CRC when it reaches that field.
  function automatic logic [135:0] build_tx_token(input resp_type_t   t,
                                                  input logic [5:0]   idx,
                                                  input logic [127:0] pl);
    logic [135:0] tok;
    case (t)
      RESP_R2: tok = {2'b00, 6'h3F, pl[127:8], 7'h7F, 1'b1};
      RESP_R3: tok = {2'b00, 6'h3F, pl[31:0], 7'h7F, 1'b1, 88'd0};
      default: tok = {2'b00, idx, pl[31:0], 7'h7F, 1'b1, 88'd0};
    endcase
    return tok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_crc7_serial.sv
`default_nettype none
// ============================================================================
// Module   : sd_crc7_serial
// Purpose  : Bit-serial CRC7 (x^7 + x^3 + 1), zero seed, MSB-first input.
// Ports    : clk      - clock
//            rst_n    - asynchronous active-low reset
//            clear_i  - synchronous clear to zero (wins over en_i)
//            en_i     - fold bit_i into the CRC this cycle
//            bit_i    - serial data bit
//            crc_o    - current CRC remainder
// Revision : 1.0  initial release
// ============================================================================
module sd_crc7_serial
  import sd_resp_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q, crc_d;
  logic       fb;

  always_comb begin
    fb    = bit_i ^ crc_q[6];
    crc_d = crc_q;
    if (clear_i) begin
      crc_d = 7'd0;
    end else if (en_i) begin
      crc_d = {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= 7'd0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule
`default_nettype wire

// File: rtl/sd_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module   : sd_cmd_responder
// Purpose  : Card side of the SD CMD line. Receives 48-bit host commands,
//            checks framing and CRC7, presents index/argument to card logic,
//            then serialises the R1/R2/R3 response that card logic supplies.
// Ports    : sd_clk        - sole clock, CMD sampled/driven on rising edge
//            rstn          - asynchronous active-low reset
//            sd_cmd_i      - CMD line from host (idles high)
//            sd_cmd_o/oe   - CMD value / drive enable from card
//            cmd_valid     - one-cycle pulse, good command received
//            cmd_index/arg - last good command fields
//            crc_err       - one-cycle pulse, framing or CRC7 failure
//            resp_valid/ready/type/payload - response offer handshake
//            busy          - high whenever not idle
// Revision : 1.0  initial release
// ============================================================================
module sd_cmd_responder
  import sd_resp_pkg::*;
#(
  parameter int NCR          = 2,
  parameter int RESP_TIMEOUT = 64
) (
  input  logic         sd_clk,
  input  logic         rstn,
  input  logic         sd_cmd_i,
  output logic         sd_cmd_o,
  output logic         sd_cmd_oe,
  output logic         cmd_valid,
  output logic [5:0]   cmd_index,
  output logic [31:0]  cmd_arg,
  output logic         crc_err,
  input  logic         resp_valid,
  output logic         resp_ready,
  input  logic [1:0]   resp_type,
  input  logic [127:0] resp_payload,
  output logic         busy
);

  state_t       state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;       // bit counter (RX and TX)
  logic [7:0]   tmr_q, tmr_d;       // timeout / NCR counter
  logic [46:0]  rx_sh_q, rx_sh_d;
  logic [135:0] tx_sh_q, tx_sh_d;
  resp_type_t   type_q, type_d;
  logic         cmd_o_q, cmd_o_d;
  logic         oe_q, oe_d;
  logic         valid_q, valid_d;
  logic         err_q, err_d;
  logic [5:0]   index_q, index_d;
  logic [31:0]  arg_q, arg_d;

  logic         rx_crc_clr, rx_crc_en;
  logic [6:0]   rx_crc;
  logic         tx_crc_clr, tx_crc_en;
  logic [6:0]   tx_crc;

  logic [47:0]  rx_tok;
  logic         rx_good;
  logic         emit;
  logic [7:0]   pos, tx_len, data_lo, data_hi;
  logic [2:0]   crc_ofs;
  logic         has_crc, in_crc_data, in_crc_field;

  // Full received token as of the cycle the end bit is on the line.
  assign rx_tok  = {rx_sh_q, sd_cmd_i};
  assign rx_good = ~rx_tok[47] & rx_tok[46] & rx_tok[0] & (rx_tok[7:1] == rx_crc);

  // Transmit bookkeeping: pos is the index of the bit about to be driven.
  // The NCR->TX edge drives bit 0, later edges drive bit cnt_q.
  assign tx_len  = (type_q == RESP_R2) ? 8'(R2_LEN) : 8'(CMD_LEN);
  assign data_lo = (type_q == RESP_R2) ? 8'd8   : 8'd0;
  assign data_hi = (type_q == RESP_R2) ? 8'd128 : 8'd40;
  assign has_crc = (type_q != RESP_R3);
  assign pos     = (state_q == ST_TX) ? cnt_q : 8'd0;
  assign emit    = ((state_q == ST_NCR) && (tmr_q == 8'(NCR - 1))) ||
                   ((state_q == ST_TX) && (cnt_q != tx_len));
  assign in_crc_data  = has_crc && (pos >= data_lo) && (pos < data_hi);
  assign in_crc_field = has_crc && (pos >= data_hi) && (pos < data_hi + 8'd7);
  assign crc_ofs      = 3'(pos - data_hi);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tmr_d      = tmr_q;
    rx_sh_d    = rx_sh_q;
    tx_sh_d    = tx_sh_q;
    type_d     = type_q;
    cmd_o_d    = 1'b1;
    oe_d       = 1'b0;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    index_d    = index_q;
    arg_d      = arg_q;
    rx_crc_clr = 1'b0;
    rx_crc_en  = 1'b0;
    tx_crc_clr = 1'b0;
    tx_crc_en  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        rx_crc_clr = 1'b1;
        if (!sd_cmd_i) begin
          state_d = ST_RX;
          cnt_d   = 8'd1;
          rx_sh_d = {rx_sh_q[45:0], sd_cmd_i};
        end
      end
      ST_RX: begin
        rx_sh_d   = {rx_sh_q[45:0], sd_cmd_i};
        // cnt_q=k samples token bit 47-k; CRC covers bits 46..8.
        rx_crc_en = (cnt_q <= 8'd39);
        cnt_d     = sat_inc8(cnt_q);
        if (cnt_q == 8'd47) begin
          state_d = ST_CHECK;
          cnt_d   = 8'd0;
          if (rx_good) begin
            valid_d = 1'b1;
            index_d = rx_tok[45:40];
            arg_d   = rx_tok[39:8];
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_CHECK: begin
        state_d = valid_q ? ST_WAIT_RESP : ST_IDLE;
        tmr_d   = 8'd0;
      end
      ST_WAIT_RESP: begin
        if (resp_valid) begin
          tmr_d = 8'd0;
          if (resp_type_t'(resp_type) == RESP_NONE) begin
            state_d = ST_IDLE;
          end else begin
            state_d    = ST_NCR;
            type_d     = resp_type_t'(resp_type);
            tx_sh_d    = build_tx_token(resp_type_t'(resp_type), index_q, resp_payload);
            tx_crc_clr = 1'b1;
            cnt_d      = 8'd0;
          end
        end else if (tmr_q == 8'(RESP_TIMEOUT - 1)) begin
          state_d = ST_IDLE;
          tmr_d   = 8'd0;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      ST_NCR: begin
        if (tmr_q == 8'(NCR - 1)) begin
          state_d = ST_TX;
          tmr_d   = 8'd0;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      ST_TX: begin
        if (cnt_q == tx_len) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (emit) begin
      oe_d      = 1'b1;
      // CRC field bits come from the running CRC, which is stable by then.
      cmd_o_d   = in_crc_field ? tx_crc[3'd6 - crc_ofs] : tx_sh_q[135];
      tx_sh_d   = {tx_sh_q[134:0], 1'b0};
      tx_crc_en = in_crc_data;
      cnt_d     = sat_inc8(pos);
    end
  end

  always_ff @(posedge sd_clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      tmr_q   <= 8'd0;
      rx_sh_q <= '0;
      tx_sh_q <= '0;
      type_q  <= RESP_NONE;
      cmd_o_q <= 1'b1;
      oe_q    <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      index_q <= 6'd0;
      arg_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      rx_sh_q <= rx_sh_d;
      tx_sh_q <= tx_sh_d;
      type_q  <= type_d;
      cmd_o_q <= cmd_o_d;
      oe_q    <= oe_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      index_q <= index_d;
      arg_q   <= arg_d;
    end
  end

  sd_crc7_serial u_rx_crc (
    .clk     (sd_clk),
    .rst_n   (rstn),
    .clear_i (rx_crc_clr),
    .en_i    (rx_crc_en),
    .bit_i   (sd_cmd_i),
    .crc_o   (rx_crc)
  );

  sd_crc7_serial u_tx_crc (
    .clk     (sd_clk),
    .rst_n   (rstn),
    .clear_i (tx_crc_clr),
    .en_i    (tx_crc_en),
    .bit_i   (tx_sh_q[135]),
    .crc_o   (tx_crc)
  );

  assign sd_cmd_o   = cmd_o_q;
  assign sd_cmd_oe  = oe_q;
  assign cmd_valid  = valid_q;
  assign crc_err    = err_q;
  assign cmd_index  = index_q;
  assign cmd_arg    = arg_q;
  assign resp_ready = (state_q == ST_WAIT_RESP);
  assign busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_cmd_responder
// Purpose  : Self-checking bench for sd_cmd_responder: directed command /
//            response cases plus randomized transactions against a
//            polynomial-division CRC7 reference.
// Revision : 1.0  initial release
// ============================================================================
module tb_sd_cmd_responder;

  localparam int NCR_P = 2;
  localparam int TMO_P = 64;

  logic         sd_clk = 1'b0;
  logic         rstn = 1'b0;
  logic         sd_cmd_i = 1'b1;
  logic         resp_valid = 1'b0;
  logic [1:0]   resp_type = 2'd0;
  logic [127:0] resp_payload = '0;
  logic         sd_cmd_o, sd_cmd_oe, cmd_valid, crc_err, resp_ready, busy;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;

  int           n_tests = 0;
  int           n_fail = 0;
  logic [5:0]   exp_idx = 6'd0;
  logic [31:0]  exp_arg = 32'd0;
  logic [135:0] last_resp = '0;

  sd_cmd_responder #(.NCR(NCR_P), .RESP_TIMEOUT(TMO_P)) dut (
    .sd_clk       (sd_clk),
    .rstn         (rstn),
    .sd_cmd_i     (sd_cmd_i),
    .sd_cmd_o     (sd_cmd_o),
    .sd_cmd_oe    (sd_cmd_oe),
    .cmd_valid    (cmd_valid),
    .cmd_index    (cmd_index),
    .cmd_arg      (cmd_arg),
    .crc_err      (crc_err),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_type    (resp_type),
    .resp_payload (resp_payload),
    .busy         (busy)
  );

  always #5 sd_clk = ~sd_clk;

  task automatic check_eq(input string tag, input logic [135:0] got, input logic [135:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Remainder of msg(x)*x^7 divided by x^7+x^3+1; msg right-aligned.
  function automatic logic [6:0] crc7_ref(input logic [135:0] msg, input int nbits);
    logic [142:0] r;
    r = {msg, 7'b0};
    for (int i = nbits + 6; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  // Expected response token, right-aligned, with its length in bits.
  function automatic logic [135:0] resp_ref(input int t, input logic [5:0] idx,
                                            input logic [127:0] pl, output int len);
    logic [39:0] h;
    if (t == 2) begin
      len = 136;
      return {8'h3F, pl[127:8], crc7_ref(136'(pl[127:8]), 120), 1'b1};
    end
    len = 48;
    if (t == 3) return 136'({8'h3F, pl[31:0], 8'hFF});
    h = {2'b00, idx, pl[31:0]};
    return 136'({h, crc7_ref(136'(h), 40), 1'b1});
  endfunction

  // corrupt: 0 none, 1 flip CRC bit 1, 2 end bit 0, 3 transmission bit 0.
  task automatic run_txn(input logic [5:0] idx, input logic [31:0] arg, input int corrupt,
                         input int rtype, input logic [127:0] pl, input bit respond,
                         input int abort_at);
    logic [39:0]  hdr;
    logic [47:0]  tok;
    logic [135:0] exp, got;
    bit           good, oe_seen;
    int           len, k, n;
    hdr = {2'b01, idx, arg};
    tok = {hdr, crc7_ref(136'(hdr), 40), 1'b1};
    if (corrupt == 1) tok[1] = ~tok[1];
    else if (corrupt == 2) tok[0] = 1'b0;
    else if (corrupt == 3) tok[46] = 1'b0;
    good = (corrupt == 0);
    for (int i = 47; i >= 0; i--) begin
      @(negedge sd_clk);
      sd_cmd_i = tok[i];
    end
    @(negedge sd_clk);
    sd_cmd_i = 1'b1;
    check_eq("rx_pulse", 136'({cmd_valid, crc_err}), 136'({good, !good}));
    if (good) begin
      exp_idx = idx;
      exp_arg = arg;
    end
    check_eq("rx_fields", 136'({cmd_index, cmd_arg}), 136'({exp_idx, exp_arg}));
    @(negedge sd_clk);
    if (!good) begin
      check_eq("rx_drop", 136'({busy, cmd_valid, crc_err}), 136'(3'b000));
      return;
    end
    check_eq("wait_entry", 136'({resp_ready, cmd_valid, crc_err}), 136'(3'b100));
    if (!respond) begin
      n = 0;
      oe_seen = 1'b0;
      while (resp_ready && n < 200) begin
        n++;
        oe_seen |= sd_cmd_oe;
        @(negedge sd_clk);
      end
      check_eq("timeout_len", 136'(n), 136'(TMO_P));
      check_eq("timeout_idle", 136'({busy, oe_seen}), 136'(2'b00));
      return;
    end
    repeat ($urandom_range(0, 3)) @(negedge sd_clk);
    resp_valid   = 1'b1;
    resp_type    = 2'(rtype);
    resp_payload = pl;
    @(negedge sd_clk);
    resp_valid   = 1'b0;
    resp_payload = {$urandom, $urandom, $urandom, $urandom};
    if (rtype == 0) begin
      check_eq("none_idle", 136'(busy), 136'(0));
      oe_seen = 1'b0;
      repeat (NCR_P + 3) begin
        oe_seen |= sd_cmd_oe;
        @(negedge sd_clk);
      end
      check_eq("none_no_drive", 136'(oe_seen), 136'(0));
      return;
    end
    exp = resp_ref(rtype, exp_idx, pl, len);
    k = 1;
    while (!sd_cmd_oe && k < 100) begin
      @(negedge sd_clk);
      k++;
    end
    check_eq("ncr_latency", 136'(k), 136'(NCR_P + 1));
    got = '0;
    n = 0;
    while (sd_cmd_oe && n < 200) begin
      got = {got[134:0], sd_cmd_o};
      n++;
      if (n == abort_at) begin
        #2 rstn = 1'b0;
        #1 check_eq("async_rst", 136'({sd_cmd_oe, sd_cmd_o, busy, cmd_index, cmd_arg}),
                    136'({1'b0, 1'b1, 1'b0, 38'd0}));
        exp_idx = 6'd0;
        exp_arg = 32'd0;
        @(negedge sd_clk);
        @(negedge sd_clk);
        rstn = 1'b1;
        @(negedge sd_clk);
        return;
      end
      @(negedge sd_clk);
    end
    last_resp = got;
    check_eq("resp_len", 136'(n), 136'(len));
    check_eq("resp_bits", got, exp);
    check_eq("resp_release", 136'({sd_cmd_oe, sd_cmd_o, busy}), 136'(3'b010));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    repeat (3) @(negedge sd_clk);
    check_eq("reset_state",
             136'({sd_cmd_o, sd_cmd_oe, cmd_valid, crc_err, resp_ready, busy, cmd_index, cmd_arg}),
             136'({1'b1, 5'b00000, 38'd0}));
    rstn = 1'b1;
    @(negedge sd_clk);

    // CMD0, no response
    run_txn(6'd0, 32'd0, 0, 0, '0, 1'b1, 0);
    // CMD8, R1 echo
    run_txn(6'd8, 32'h1AA, 0, 1, 128'h1AA, 1'b1, 0);
    check_eq("cmd8_line", last_resp, 136'h08000001AA13);
    // CMD0 with CRC byte 0x97, then with end bit 0
    run_txn(6'd0, 32'd0, 1, 0, '0, 1'b1, 0);
    run_txn(6'd0, 32'd0, 2, 0, '0, 1'b1, 0);
    // CMD2, R2 with a CID
    run_txn(6'd2, 32'd0, 0, 2, 128'h035344534430334780_1234_5678_0119_01, 1'b1, 0);
    check_eq("r2_header", 136'(last_resp[135:128]), 136'(8'h3F));
    // CMD41, R3 then timeout
    run_txn(6'd41, 32'h40FF8000, 0, 3, 128'h80FF8000, 1'b1, 0);
    check_eq("r3_line", last_resp, 136'h3F80FF8000FF);
    run_txn(6'd41, 32'h40FF8000, 0, 3, 128'h80FF8000, 1'b0, 0);
    // Reset mid-TX at bit 20, then a fresh CMD0
    run_txn(6'd8, 32'h1AA, 0, 1, 128'h1AA, 1'b1, 20);
    run_txn(6'd0, 32'd0, 0, 0, '0, 1'b1, 0);
    check_eq("post_rst_cmd0", 136'({cmd_index, cmd_arg}), 136'(38'd0));

    for (int t = 0; t < 40; t++) begin
      int c, rt;
      bit rsp;
      c   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
      rt  = int'($urandom_range(0, 3));
      rsp = ($urandom_range(0, 7) != 0);
      resp_valid = 1'($urandom_range(0, 1));
      resp_type  = 2'($urandom_range(1, 3));
      @(negedge sd_clk);
      check_eq("idle_ignores_resp", 136'({busy, sd_cmd_oe, resp_ready}), 136'(3'b000));
      resp_valid = 1'b0;
      run_txn(6'($urandom), $urandom, c, rt, {$urandom, $urandom, $urandom, $urandom}, rsp, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sd_cmd_responder.md
Name: sd_cmd_responder

Overview:
- Card-side counterpart of the SD host command path: deserialises 48-bit host command tokens from the CMD line, checks framing and CRC7, and hands index/argument to local card logic.
- Serialises the 48-bit or 136-bit response token that the card logic supplies.
- Sits in the SD card emulation model and loopback bench, wired to the host controller's sd_cmd_to_mem / sd_cmd_oe / sd_cmd_to_host pins.

Parameters:
- NCR, 2, sd_clk cycles from response accept to start bit; legal range 2..64.
- RESP_TIMEOUT, 64, cycles in WAIT_RESP before the command is dropped with no response.

Ports:
- sd_clk  in  1  sole clock; CMD line sampled and driven on rising edge
- rstn  in  1  asynchronous active-low reset
- sd_cmd_i  in  1  CMD line as driven by host; idles high
- sd_cmd_o  out  1  CMD line value driven by card
- sd_cmd_oe  out  1  card drives CMD when 1
- cmd_valid  out  1  one-cycle pulse: good command received
- cmd_index  out  6  command index, held until next cmd_valid
- cmd_arg  out  32  command argument, held until next cmd_valid
- crc_err  out  1  one-cycle pulse: framing or CRC7 failure
- resp_valid  in  1  card logic offers a response
- resp_ready  out  1  high only in WAIT_RESP; accept = resp_valid & resp_ready
- resp_type  in  2  0 none, 1 R1-style (index + CRC), 2 R2 136-bit, 3 R3 (index/CRC forced to all-ones)
- resp_payload  in  128  R1/R3 use [31:0]; R2 uses [127:8]
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state IDLE, sd_cmd_o=1, sd_cmd_oe=0, cmd_valid=0, crc_err=0, resp_ready=0, busy=0, cmd_index=0, cmd_arg=0, all counters 0. Reset mid-transfer releases the line in the same instant (async).
- IDLE: sample sd_cmd_i; 0 -> RX with bit counter=1.
- RX: shift 47 further bits MSB-first; serial CRC7 (x^7+x^3+1, zero seed) runs over bits 47..8. After bit 0 -> CHECK.
- CHECK (1 cycle): good = transmission bit==1, end bit==1, received CRC==computed. Good -> cmd_valid pulse, index/arg latched, -> WAIT_RESP. Bad -> crc_err pulse, -> IDLE; no response, outputs unchanged.
- cmd_valid and crc_err are asserted the cycle after the end bit is sampled.
- WAIT_RESP: resp_ready=1; timeout counter increments.
  - Accept with type 0 -> IDLE.
  - Accept with type 1..3 -> NCR; type and payload latched.
  - Counter reaching RESP_TIMEOUT with no accept -> IDLE silently.
  - resp_valid outside WAIT_RESP is ignored.
- NCR: line stays released for NCR-1 cycles. The start bit appears with sd_cmd_oe=1 exactly NCR cycles after the accept edge.
- TX: one bit per cycle, MSB-first, registered outputs.
  - R1: 0,0,index[5:0],payload[31:0],CRC7 over the first 40 bits,1.
  - R3: 0,0,111111,payload[31:0],1111111,1.
  - R2: 0,0,111111,payload[127:8], CRC7 over payload[127:8] only, 1 (136 bits).
- After the end bit: sd_cmd_oe=0 and sd_cmd_o=1 on the next cycle -> IDLE. sd_cmd_i is ignored during NCR and TX.
- Bit counter is 8 bits and saturates; it never wraps within a token.

Decomposition:
- Shared package sd_resp_pkg:
  - resp_type_t enum (RESP_NONE, RESP_R1, RESP_R2, RESP_R3)
  - state enum (IDLE, RX, CHECK, WAIT_RESP, NCR, TX)
  - constants CMD_LEN=48, R2_LEN=136, CRC7_POLY=7'h09
- Sub-module sd_crc7_serial: clear, enable, bit in; crc[6:0] out. Instantiated twice, once for RX and once for TX.

Test Plan:
- CMD0 token 0x40_00000000_95 -> cmd_valid with index 0, arg 0; type 0 accepted -> sd_cmd_oe never rises.
- CMD8 token 0x48_000001AA_87; respond type 1, payload 0x000001AA -> line carries 0x08_000001AA_13. Start bit lands exactly 2 cycles after accept; oe is high for exactly 48 cycles.
- CMD0 token with CRC byte 0x97, and separately with end bit 0 -> crc_err pulse, no cmd_valid, busy low the next cycle.
- CMD2, R2 response with a known CID -> 136 bits on the line, bits 135..128 = 0x3F, CRC7 matches a reference model, end bit 1.
- CMD41, R3 payload 0x80FF8000 -> 0x3F_80FF8000_FF. Repeat with resp_valid held low -> return to IDLE after 64 cycles with no drive.
- Assert rstn low mid-TX at bit 20 -> sd_cmd_oe=0 immediately. After release, a fresh CMD0 is decoded correctly.
